// File: rtl/data_mem_responder.sv
// Load/store data-memory responder: byte-addressable little-endian RAM behind a
// one-outstanding valid/ready request port, replying after a fixed latency.
module data_mem_responder #(
    parameter int unsigned DEPTH_BYTES = 2048,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_load_opr,
    input  logic [1:0]  req_store_opr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [63:0]        r_rsp_rdata;
    logic [7:0]         r_mem [DEPTH_BYTES];

    logic               w_accept;
    logic [1:0]         w_size;
    logic               w_misalign;
    logic               w_range_err;
    logic               w_opr_err;
    logic               w_err;
    logic [ADDR_W-1:0]  w_idx;
    logic [7:0]         w_byte_en;
    logic [63:0]        w_raw;
    logic [63:0]        w_load;

    assign req_ready = (r_state == StIdle) && rst_n;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Size encoding is log2(bytes) for both opcode fields.
    assign w_size      = req_wr ? req_store_opr : req_load_opr[1:0];
    assign w_range_err = |req_addr[63:ADDR_W];
    assign w_opr_err   = !req_wr && (req_load_opr == 3'b111);
    assign w_err       = w_misalign || w_range_err || w_opr_err;
    assign w_idx       = req_addr[ADDR_W-1:0];

    always_comb begin
        w_misalign = 1'b0;
        w_byte_en  = 8'h01;
        case (w_size)
            2'd0: begin
                w_misalign = 1'b0;
                w_byte_en  = 8'h01;
            end
            2'd1: begin
                w_misalign = req_addr[0];
                w_byte_en  = 8'h03;
            end
            2'd2: begin
                w_misalign = |req_addr[1:0];
                w_byte_en  = 8'h0F;
            end
            default: begin
                w_misalign = |req_addr[2:0];
                w_byte_en  = 8'hFF;
            end
        endcase
    end

    // Aligned accesses never cross the top of the array, so the index may wrap freely.
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < 8; i++) begin
            w_raw[8*i +: 8] = r_mem[w_idx + ADDR_W'(i)];
        end
    end

    always_comb begin
        w_load = '0;
        case (req_load_opr)
            3'b000:  w_load = {{56{w_raw[7]}}, w_raw[7:0]};
            3'b001:  w_load = {{48{w_raw[15]}}, w_raw[15:0]};
            3'b010:  w_load = {{32{w_raw[31]}}, w_raw[31:0]};
            3'b011:  w_load = w_raw;
            3'b100:  w_load = {56'd0, w_raw[7:0]};
            3'b101:  w_load = {48'd0, w_raw[15:0]};
            3'b110:  w_load = {32'd0, w_raw[31:0]};
            default: w_load = '0;
        endcase
    end

    // Array is deliberately not reset; stores commit at the acceptance edge.
    always_ff @(posedge clk) begin
        if (w_accept && req_wr && !w_err) begin
            for (int i = 0; i < 8; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_idx + ADDR_W'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || req_wr) ? 64'd0 : w_load;
                        if (LATENCY == 1) begin
                            r_state     <= StResp;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= StBusy;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                StBusy: begin
                    if (r_cnt == '0) begin
                        r_state     <= StResp;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_state     <= StIdle;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed cases plus randomized traffic
// checked against a byte-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 2048;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [2:0]  req_load_opr;
    logic [1:0]  req_store_opr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    data_mem_responder #(
        .DEPTH_BYTES(DEPTH),
        .ADDR_W     (11),
        .LATENCY    (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_load_opr (req_load_opr),
        .req_store_opr(req_store_opr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  m_mem [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rr_mode = 0;   // 0 random, 1 hold low, 2 hold high

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                1:       rsp_ready = 1'b0;
                2:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    // Reference behaviour: sizes, alignment, range, extension from plain arithmetic.
    function automatic void model(input bit wr, input logic [63:0] a, input logic [2:0] lo,
                                  input logic [1:0] so, input logic [63:0] wd,
                                  output logic [63:0] rd, output logic er);
        int          sz;
        int          base;
        logic [63:0] v;
        sz = wr ? (1 << so) : (1 << lo[1:0]);
        er = (a >= 64'(DEPTH)) || ((a % 64'(sz)) != 0) || (!wr && lo == 3'd7);
        rd = '0;
        if (er) return;
        base = int'(a[10:0]);
        if (wr) begin
            for (int b = 0; b < sz; b++) m_mem[base + b] = wd[8*b +: 8];
        end else begin
            v = '0;
            for (int b = 0; b < sz; b++) v = v | (64'(m_mem[base + b]) << (8 * b));
            if (lo < 3'd3 && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
            rd = v;
        end
    endfunction

    task automatic issue(input bit wr, input logic [63:0] a, input logic [2:0] lo,
                         input logic [1:0] so, input logic [63:0] wd,
                         input bit use_c, input logic [63:0] c_rd, input logic c_er);
        exp_t        e;
        logic [63:0] rd;
        logic        er;
        int          n;
        @(negedge clk);
        req_valid     = 1'b1;
        req_wr        = wr;
        req_addr      = a;
        req_load_opr  = lo;
        req_store_opr = so;
        req_wdata     = wd;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model(wr, a, lo, so, wd, rd, er);
        e.rdata = use_c ? c_rd : rd;
        e.err   = use_c ? c_er : er;
        e.acc   = cyc;
        q.push_back(e);
    endtask

    // Monitor: latency on each new response, data/err on each handshake.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (rsp_valid && !prev) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_rsp: got rsp_valid=1, expected no response");
                    end else begin
                        check("latency", 64'(cyc - q[0].acc), 64'(LAT));
                    end
                end
                if (rsp_valid && rsp_ready && q.size() != 0) begin
                    e = q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
                prev = rsp_valid;
            end
        end
    end

    initial begin
        int          n;
        bit          wr;
        logic [2:0]  lo;
        logic [1:0]  so;
        logic [63:0] a;
        int          sz;

        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_wr        = 1'b0;
        req_addr      = '0;
        req_load_opr  = '0;
        req_store_opr = '0;
        req_wdata     = '0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < DEPTH / 8; i++) begin
            issue(1'b1, 64'(i * 8), 3'd0, 2'd3, {$urandom, $urandom}, 1'b0, '0, 1'b0);
        end

        // Directed cases
        issue(1'b1, 64'h10, 3'd0, 2'd3, 64'h8877665544332211, 1'b1, 64'd0, 1'b0);
        issue(1'b0, 64'h10, 3'd3, 2'd0, 64'd0, 1'b1, 64'h8877665544332211, 1'b0);
        issue(1'b1, 64'h20, 3'd0, 2'd0, 64'h80, 1'b1, 64'd0, 1'b0);
        issue(1'b0, 64'h20, 3'd0, 2'd3, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0);
        issue(1'b0, 64'h20, 3'd4, 2'd3, 64'd0, 1'b1, 64'h0000000000000080, 1'b0);
        issue(1'b1, 64'h40, 3'd0, 2'd2, 64'hDEADBEEF, 1'b1, 64'd0, 1'b0);
        issue(1'b0, 64'h42, 3'd1, 2'd0, 64'd0, 1'b1, 64'hFFFFFFFFFFFFDEAD, 1'b0);
        issue(1'b0, 64'h40, 3'd6, 2'd0, 64'd0, 1'b1, 64'h00000000DEADBEEF, 1'b0);
        issue(1'b0, 64'h2, 3'd2, 2'd0, 64'd0, 1'b1, 64'd0, 1'b1);
        issue(1'b1, 64'h800, 3'd0, 2'd3, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'd0, 1'b1);
        issue(1'b0, 64'h0, 3'd3, 2'd0, 64'd0, 1'b0, '0, 1'b0);
        issue(1'b1, 64'h7FF, 3'd0, 2'd0, 64'h5A, 1'b1, 64'd0, 1'b0);
        issue(1'b0, 64'h7FF, 3'd4, 2'd0, 64'd0, 1'b1, 64'h5A, 1'b0);
        issue(1'b0, 64'h7FF, 3'd1, 2'd0, 64'd0, 1'b1, 64'd0, 1'b1);
        issue(1'b0, 64'h8, 3'd7, 2'd0, 64'd0, 1'b1, 64'd0, 1'b1);

        // Response back-pressure: outputs must hold while rsp_ready stays low
        issue(1'b1, 64'h58, 3'd0, 2'd3, 64'h0123456789ABCDEF, 1'b1, 64'd0, 1'b0);
        issue(1'b0, 64'h58, 3'd3, 2'd0, 64'd0, 1'b1, 64'h0123456789ABCDEF, 1'b0);
        rr_mode = 1;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_rdata", rsp_rdata, 64'h0123456789ABCDEF);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rr_mode = 2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("post_hs_req_ready", 64'(req_ready), 64'd1);
        check("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        rr_mode = 0;

        // Reset during BUSY of a store: response dropped, store retained
        issue(1'b1, 64'h30, 3'd0, 2'd3, 64'hCAFEF00D12345678, 1'b1, 64'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_rsp_rdata", rsp_rdata, 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 64'h30, 3'd3, 2'd0, 64'd0, 1'b1, 64'hCAFEF00D12345678, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wr = ($urandom_range(0, 1) == 1);
            lo = 3'($urandom_range(0, 7));
            so = 2'($urandom_range(0, 3));
            sz = wr ? (1 << so) : (1 << lo[1:0]);
            case ($urandom_range(0, 9))
                0:       a = 64'h7FF;
                1:       a = 64'd1 << $urandom_range(11, 63);
                2:       a = 64'($urandom_range(0, DEPTH - 1));
                default: a = 64'($urandom_range(0, DEPTH - 1)) & ~64'(sz - 1);
            endcase
            issue(wr, a, lo, so, {$urandom, $urandom}, 1'b0, '0, 1'b0);
        end

        rr_mode = 2;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
